// File: rtl/multiplicador_secuencial.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// WIDTH iterations, registered product held until the next completed operation.
module multiplicador_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      p_q      <= p_d;
    end
  end

  // Accumulator value including the current iteration's partial product.
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // NOTE: every signal driven here gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    p_d      = p_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          p_d     = sum;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule
